shift_arb: RTL
==============

// Module: shift_arb
// PURPOSE
//  Shares one 64-bit right-shift unit (1-cycle registered, one-hot shift select,
//  init/done handshake) between N_REQ requesters. Arbitrates requests, decodes
//  binary shift amounts to one-hot, and sequences init/done on the unit.
//  Returns each result through a per-requester response register.
//  Sits between transform/quant stages and the shared shifter.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  IDX_W   $clog2(N_REQ)   owner index width (derived, do not override)
// PORTS
//  clk_i         in   1          clock
//  rst_n_i       in   1          reset, asynchronous, active-low
//  req_valid_i   in   N_REQ      request valid per requester
//  req_ready_o   out  N_REQ      request accepted (one-hot, 1-cycle pulse)
//  req_arith_i   in   N_REQ      1=arithmetic, 0=logical shift
//  req_shamt_i   in   N_REQ x 6  binary shift amount 0..63
//  req_data_i    in   N_REQ x 64 operand
//  rsp_valid_o   out  N_REQ      result held in response register
//  rsp_ready_i   in   N_REQ      requester consumes result
//  rsp_data_o    out  N_REQ x 64 result
//  sh_init_o     out  1          init strobe to shifter
//  sh_arith_o    out  1          arith select to shifter
//  sh_shift_o    out  64         one-hot shift select to shifter
//  sh_data_o     out  64         operand to shifter
//  sh_done_i     in   1          shifter done
//  sh_data_i     in   64         shifter result
//  busy_o        out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, all rsp slots empty, RR pointer=0.
//  Reset mid-operation drops the in-flight op and all pending responses.
//  Eligibility: req_valid_i[k] & ~rsp_valid_o[k]. A slot draining this cycle is
//  not yet eligible.
//  FSM IDLE->ISSUE->WAIT->IDLE:
//   IDLE: if any requester is eligible, pick winner w, pulse req_ready_o[w]
//     this cycle, and latch arith/shamt/data/owner=w. Go to ISSUE.
//   ISSUE: sh_init_o=1 for exactly one cycle. Go to WAIT.
//   WAIT: sh_init_o=0. On sh_done_i, load sh_data_i into rsp_data_o[owner] and set
//     rsp_valid_o[owner] next edge. Go to IDLE. Without sh_done_i, stay in WAIT
//     indefinitely.
//  sh_arith_o/sh_data_o/sh_shift_o: driven from latched operands in ISSUE and
//  WAIT, and 0 in IDLE.
//  Decode: shamt=0 -> sh_shift_o=64'h0 (unit passes data through).
//   shamt=k (1..63) -> sh_shift_o = 64'h1<<k.
//  Latency: accept at edge T; init high in T+1; done in T+2; rsp_valid_o high
//  from T+3. Peak rate is 1 op per 3 cycles.
//  Response: rsp_valid_o[k] stays high with data stable until rsp_ready_i[k];
//  it clears on the next edge. One slot per requester; a full slot blocks only
//  that requester.
//  sh_done_i outside WAIT is ignored.
//  rsp_ready_i with rsp_valid_o low is ignored.
// CONFIGURATION
//  SHIFT_ARB_RR_EN defined: round-robin. Search starts at the pointer; on each
//  grant, pointer <= w+1 mod N_REQ.
//  SHIFT_ARB_RR_EN undefined: fixed priority, lowest index wins, no pointer
//  register.
// TESTING
//  T1 req0 data=64'h8000_0000_0000_0000, shamt=4, arith=1 -> sh_shift_o=64'h10,
//     rsp_data_o[0]=64'hF800_0000_0000_0000 at T+3.
//  T2 same operand with arith=0 -> 64'h0800_0000_0000_0000; shamt=0 ->
//     sh_shift_o=0, result equals operand.
//  T3 req0..3 valid continuously, all rsp_ready=1, RR build -> grants 0,1,2,3,0
//     every 3 cycles. Fixed build -> req0 always granted.
//  T4 req2 rsp_ready=0 after one result -> req2 not re-granted, req_ready_o[2]=0,
//     others keep being served. rsp_ready_i[2]=1 -> req2 eligible next cycle.
//  T5 hold sh_done_i low in WAIT for 5 cycles -> FSM stays in WAIT, busy_o=1,
//     no req_ready_o. Done arrives -> result lands in owner's slot.
//  T6 assert rst_n_i low during WAIT -> all outputs 0 asynchronously. After
//     release, no stale rsp_valid_o; next request completes normally.

Source files
------------

// File: rtl/shift_arb.sv
// Arbitrates N_REQ requesters onto one shared 64-bit right shifter with per-requester response slots.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module shift_arb #(
    parameter int N_REQ = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [N_REQ-1:0]      req_arith_i,
    input  logic [N_REQ*6-1:0]    req_shamt_i,
    input  logic [N_REQ*64-1:0]   req_data_i,
    output logic [N_REQ-1:0]      rsp_valid_o,
    input  logic [N_REQ-1:0]      rsp_ready_i,
    output logic [N_REQ*64-1:0]   rsp_data_o,
    output logic                  sh_init_o,
    output logic                  sh_arith_o,
    output logic [63:0]           sh_shift_o,
    output logic [63:0]           sh_data_o,
    input  logic                  sh_done_i,
    input  logic [63:0]           sh_data_i,
    output logic                  busy_o
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [IDX_W-1:0] owner_r;
    logic [IDX_W-1:0] win_s;
    logic [IDX_W-1:0] ptr_s;
    logic [N_REQ-1:0] elig_s;
    logic [N_REQ-1:0] grant_s;
    logic [N_REQ-1:0] rsp_valid_r;
    logic             found_s;
    logic             accept_s;
    logic             done_s;
    logic             sh_arith_r;
    logic [63:0]      sh_shift_r;
    logic [63:0]      sh_data_r;
    logic [63:0]      rsp_data_r [N_REQ];

    // Shift amount 0 maps to an all-zero select so the unit passes data through.
    function automatic logic [63:0] decode_shamt(input logic [5:0] shamt);
        logic [63:0] onehot;
        if (shamt == 6'd0) begin
            onehot = 64'h0;
        end else begin
            onehot = 64'h1 << shamt;
        end
        return onehot;
    endfunction

    assign elig_s   = req_valid_i & ~rsp_valid_r;
    assign accept_s = found_s && (state_r == ST_IDLE);
    assign done_s   = (state_r == ST_WAIT) && sh_done_i;

`ifdef SHIFT_ARB_RR_EN
    logic [IDX_W-1:0] ptr_r;

    // Round-robin pointer moves one past each winner.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            ptr_r <= (win_s == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : win_s + 1'b1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`else
    assign ptr_s = {IDX_W{1'b0}};
`endif

    // Scan eligible requesters starting at the search pointer; first hit wins.
    always_comb begin
        found_s = 1'b0;
        win_s   = {IDX_W{1'b0}};
        grant_s = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_s && elig_s[(int'(ptr_s) + i) % N_REQ]) begin
                found_s = 1'b1;
                win_s   = IDX_W'((int'(ptr_s) + i) % N_REQ);
            end else begin
                found_s = found_s;
            end
        end
        if (accept_s) begin
            grant_s[win_s] = 1'b1;
        end else begin
            grant_s = {N_REQ{1'b0}};
        end
    end

    // Next-state logic for the issue sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_ISSUE;
                else          state_nxt_s = ST_IDLE;
            end
            ST_ISSUE: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (sh_done_i) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_WAIT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Latch the winner's operands on accept; zero them once the op completes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner_r    <= {IDX_W{1'b0}};
            sh_arith_r <= 1'b0;
            sh_shift_r <= 64'h0;
            sh_data_r  <= 64'h0;
        end else if (accept_s) begin
            owner_r    <= win_s;
            sh_arith_r <= req_arith_i[win_s];
            sh_shift_r <= decode_shamt(req_shamt_i[int'(win_s)*6 +: 6]);
            sh_data_r  <= req_data_i[int'(win_s)*64 +: 64];
        end else if (done_s) begin
            owner_r    <= owner_r;
            sh_arith_r <= 1'b0;
            sh_shift_r <= 64'h0;
            sh_data_r  <= 64'h0;
        end else begin
            owner_r    <= owner_r;
            sh_arith_r <= sh_arith_r;
            sh_shift_r <= sh_shift_r;
            sh_data_r  <= sh_data_r;
        end
    end

    // Response slots: filled on done for the owner, emptied when the requester takes the result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_r <= {N_REQ{1'b0}};
            for (int k = 0; k < N_REQ; k++) rsp_data_r[k] <= 64'h0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (done_s && (owner_r == IDX_W'(k))) begin
                    rsp_valid_r[k] <= 1'b1;
                    rsp_data_r[k]  <= sh_data_i;
                end else if (rsp_ready_i[k]) begin
                    rsp_valid_r[k] <= 1'b0;
                    rsp_data_r[k]  <= rsp_data_r[k];
                end else begin
                    rsp_valid_r[k] <= rsp_valid_r[k];
                    rsp_data_r[k]  <= rsp_data_r[k];
                end
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_rsp
        assign rsp_data_o[g*64 +: 64] = rsp_data_r[g];
    end

    // The grant is combinational, so it is masked during reset to keep outputs quiet.
    assign req_ready_o = grant_s & {N_REQ{rst_n_i}};
    assign rsp_valid_o = rsp_valid_r;
    assign sh_init_o   = (state_r == ST_ISSUE);
    assign sh_arith_o  = sh_arith_r;
    assign sh_shift_o  = sh_shift_r;
    assign sh_data_o   = sh_data_r;
    assign busy_o      = (state_r != ST_IDLE);

endmodule
